iir_biquad_cascade: RTL and testbench
=====================================

# iir_biquad_cascade

Time-multiplexed, multi-channel cascade of NUM_STAGES direct-form-I biquad sections sharing one 16x16 signed multiply-accumulate unit. It sits in the audio path after the sample deserialiser and replaces the single-section filter. It adds:
- configurable section count and channel count
- double-buffered coefficients with glitch-free commit
- rounding and saturation
- per-sample bypass and a history-clear command

## Interface
- DATA_W, 16: sample width, signed Q1.(DATA_W-1)
- COEF_W, 16: coefficient width, signed Q2.COEF_FRAC
- COEF_FRAC, 14: coefficient fractional bits; 1.0 = 2^COEF_FRAC
- NUM_STAGES, 2: cascaded biquad sections, 1..8
- NUM_CH, 2: independent channels, 1..4
- ACC_W, DATA_W+COEF_W+4: accumulator width
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  sample offered
- in_ready  out  1  block can accept; high only in IDLE
- in_data  in  DATA_W  x[n], signed
- in_channel  in  max(1,clog2(NUM_CH))  channel of x[n]
- in_bypass  in  1  sampled at accept; output = input, history untouched
- out_valid  out  1  one-cycle strobe, result valid
- out_data  out  DATA_W  y[n] of last section, signed
- out_channel  out  max(1,clog2(NUM_CH))  channel of out_data
- out_sat  out  1  any section saturated for this sample (valid with out_valid)
- coef_we  in  1  write coef_data to shadow bank
- coef_addr  in  clog2(5*NUM_STAGES)  stage*5 + tap; tap 0..4 = b0,b1,b2,a1,a2
- coef_data  in  COEF_W  coefficient, signed
- coef_commit  in  1  request shadow-to-active copy
- clear_state  in  1  request zeroing of all x/y history, all channels
- busy  out  1  not IDLE, or a commit/clear request is pending

## Operation
- Section math, per stage s: acc = b0·x0 + b1·x1 + b2·x2 − a1·y1 − a2·y2, evaluated with full-precision products sign-extended to ACC_W.
- Normalisation: y = (acc + 2^(COEF_FRAC−1)) >>> COEF_FRAC (round half up), then saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1]. If clipped, set out_sat.
- Cascade: the saturated y of stage s is x0 of stage s+1. History per (channel, stage) is x1, x2, y1, y2 at DATA_W, updated only after that stage's NORM cycle (x2←x1, x1←x0, y2←y1, y1←y).
- FSM states:
  - IDLE → MAC on accept.
  - MAC: tap counter 0..4.
  - MAC → NORM after tap 4.
  - NORM → MAC (next stage) or DONE after the last stage.
  - DONE → IDLE.
- Bypass: same state sequence and latency. Multiplier results are discarded, out_data = in_data, out_sat = 0, and no history is written.
- Coefficients: coef_we writes the shadow bank in any state, with no effect on active math. coef_commit sets a pending flag. The copy happens in the first IDLE cycle, and a sample accepted in that same cycle uses the new set. clear_state behaves the same way, with the same precedence. Commit and clear in the same cycle both execute.
- Unused coef_addr values (≥ 5·NUM_STAGES) are ignored.

## Timing
- Accept when in_valid & in_ready at a rising edge. in_data, in_channel and in_bypass are registered at that edge.
- Latency: out_valid is high exactly 6·NUM_STAGES+1 cycles after the accept edge (13 for defaults).
- in_ready rises in the same cycle as out_valid.
- Minimum sample spacing is 6·NUM_STAGES+2 cycles.
- in_ready = 0 whenever a commit or clear is pending, until the cycle after it executes.
- Reset values:
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_channel=0, out_sat=0, busy=0.
  - Both coefficient banks hold identity: b0 = 2^COEF_FRAC, all other taps 0.
  - History is all zero; pending flags are cleared.
- Reset mid-operation aborts immediately. The partially computed sample is lost and no out_valid is produced.

## Structure
- Package iir_pkg: state_t enum (IDLE, MAC, NORM, DONE), tap index constants, the saturate/round function, and the identity-coefficient constant.
- Sub-module iir_mac: registered A×B product plus ACC_W accumulator with clear/add/subtract controls. The top level instantiates exactly one.
- History and coefficient banks are flop arrays in the top level.

## Test plan
- After reset, NUM_STAGES=2, no writes: send 12345 on ch0 → out_data 12345 at cycle 13, out_sat 0.
- NUM_STAGES=1, b0=8192, b1=4096, rest 0: input 16384, 0, 0 → 8192, 4096, 0.
- NUM_STAGES=1, b0=16384, a1=−8192: impulse 16384 then zeros → 16384, 8192, 4096, 2048.
- NUM_STAGES=1, b0=32767: x=32767 → 32767 with out_sat=1; x=−32768 → −32768 with out_sat=1.
- Channel independence, using the feedback filter above: impulse on ch0, zeros on ch1 interleaved → ch1 outputs stay 0 and the ch0 sequence matches the single-channel result. Then assert clear_state → the next ch0 zero-input output is 0.
- Commit during busy: write b0=8192 and pulse coef_commit mid-sample → the in-flight sample uses the old b0 and the next sample is halved. Reset asserted at MAC tap 2 → no out_valid, and all outputs take their reset values.

Source files
------------

// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared types, tap indices and rounding helpers for the biquad cascade
package iir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, NORM, DONE} state_t;
  typedef enum logic [1:0] {MAC_HOLD, MAC_CLR, MAC_ADD, MAC_SUB} mac_op_t;

  localparam int NUM_TAPS = 5;
  localparam logic [2:0] TAP_B0 = 3'd0;
  localparam logic [2:0] TAP_B1 = 3'd1;
  localparam logic [2:0] TAP_B2 = 3'd2;
  localparam logic [2:0] TAP_A1 = 3'd3;
  localparam logic [2:0] TAP_A2 = 3'd4;

  typedef struct packed {
    logic        sat;
    logic [31:0] y;
  } sat_res_t;

  // Identity section: b0 = 1.0, every other tap zero.
  function automatic logic [31:0] identity_coef(input int tap, input int frac);
    return (tap == 0) ? (32'd1 << frac) : 32'd0;
  endfunction

  // Round half up, then clip to a data_w-bit signed range.
  function automatic sat_res_t round_sat(input logic signed [63:0] acc, input int frac,
                                         input int data_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t res;
    r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    res.sat = 1'b0;
    res.y   = r[31:0];
    if (r > hi) begin
      res.y   = hi[31:0];
      res.sat = 1'b1;
    end else if (r < lo) begin
      res.y   = lo[31:0];
      res.sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/iir_biquad_cascade_mac.sv
// rtl/iir_biquad_cascade_mac.sv - shared registered multiplier with clear/add/subtract accumulator
module iir_mac
  import iir_pkg::*;
#(
  parameter int A_W   = 16,
  parameter int B_W   = 16,
  parameter int ACC_W = 36
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [A_W-1:0]     a,
  input  logic signed [B_W-1:0]     b,
  input  mac_op_t                   op,
  output logic signed [A_W+B_W-1:0] prod,
  output logic signed [ACC_W-1:0]   acc
);

  localparam int P_W = A_W + B_W;

  logic signed [ACC_W-1:0] prod_ext;
  assign prod_ext = {{(ACC_W - P_W){prod[P_W-1]}}, prod};

  // The accumulator consumes the product registered in the previous cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod <= '0;
      acc  <= '0;
    end else begin
      prod <= P_W'(a) * P_W'(b);
      case (op)
        MAC_CLR: acc <= '0;
        MAC_ADD: acc <= acc + prod_ext;
        MAC_SUB: acc <= acc - prod_ext;
        default: acc <= acc;
      endcase
    end
  end

endmodule

// File: rtl/iir_biquad_cascade.sv
// rtl/iir_biquad_cascade.sv - time-multiplexed multi-channel DF-I biquad cascade on one MAC
module iir_biquad_cascade
  import iir_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 16,
  parameter int COEF_FRAC  = 14,
  parameter int NUM_STAGES = 2,
  parameter int NUM_CH     = 2,
  parameter int ACC_W      = DATA_W + COEF_W + 4
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic signed [DATA_W-1:0]                      in_data,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] in_channel,
  input  logic                                          in_bypass,
  output logic                                          out_valid,
  output logic signed [DATA_W-1:0]                      out_data,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_channel,
  output logic                                          out_sat,
  input  logic                                          coef_we,
  input  logic [$clog2(5*NUM_STAGES)-1:0]               coef_addr,
  input  logic signed [COEF_W-1:0]                      coef_data,
  input  logic                                          coef_commit,
  input  logic                                          clear_state,
  output logic                                          busy
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ST_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int NCOEF = NUM_TAPS * NUM_STAGES;
  localparam int CA_W  = $clog2(NCOEF);
  localparam int P_W   = DATA_W + COEF_W;

  state_t                   state;
  logic [2:0]               tap;
  logic [ST_W-1:0]          stage;
  logic [CH_W-1:0]          ch;
  logic                     byp;
  logic                     sat_acc;
  logic                     commit_pend;
  logic                     clear_pend;
  logic signed [DATA_W-1:0] cur_x;

  logic signed [COEF_W-1:0] shadow [NCOEF];
  logic signed [COEF_W-1:0] active [NCOEF];
  logic signed [DATA_W-1:0] hx1 [NUM_CH][NUM_STAGES];
  logic signed [DATA_W-1:0] hx2 [NUM_CH][NUM_STAGES];
  logic signed [DATA_W-1:0] hy1 [NUM_CH][NUM_STAGES];
  logic signed [DATA_W-1:0] hy2 [NUM_CH][NUM_STAGES];

  logic [CA_W-1:0]          coef_idx;
  logic signed [DATA_W-1:0] mac_a;
  logic signed [COEF_W-1:0] mac_b;
  mac_op_t                  mac_op;
  logic signed [P_W-1:0]    prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_final;
  sat_res_t                 norm;
  logic signed [DATA_W-1:0] y_new;
  logic                     unused_hi;

  iir_mac #(.A_W(DATA_W), .B_W(COEF_W), .ACC_W(ACC_W)) u_mac (
    .clk(clk), .reset(reset), .a(mac_a), .b(mac_b), .op(mac_op), .prod(prod), .acc(acc)
  );

  // Feedback taps are subtracted one cycle late; the a2 product is folded in during NORM.
  always_comb begin
    coef_idx = CA_W'(NUM_TAPS * int'(stage) + int'(tap));
    mac_b    = active[coef_idx];
    case (tap)
      TAP_B0:  mac_a = cur_x;
      TAP_B1:  mac_a = hx1[ch][stage];
      TAP_B2:  mac_a = hx2[ch][stage];
      TAP_A1:  mac_a = hy1[ch][stage];
      default: mac_a = hy2[ch][stage];
    endcase
    mac_op = MAC_HOLD;
    if (state == MAC) begin
      if (tap == TAP_B0)      mac_op = MAC_CLR;
      else if (tap == TAP_A2) mac_op = MAC_SUB;
      else                    mac_op = MAC_ADD;
    end
    acc_final = acc - {{(ACC_W - P_W){prod[P_W-1]}}, prod};
    norm      = round_sat({{(64 - ACC_W){acc_final[ACC_W-1]}}, acc_final}, COEF_FRAC, DATA_W);
    y_new     = norm.y[DATA_W-1:0];
  end

  assign unused_hi = ^norm.y[31:DATA_W];
  assign busy      = (state != IDLE) || commit_pend || clear_pend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tap         <= '0;
      stage       <= '0;
      ch          <= '0;
      byp         <= 1'b0;
      sat_acc     <= 1'b0;
      cur_x       <= '0;
      commit_pend <= 1'b0;
      clear_pend  <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_channel <= '0;
      out_sat     <= 1'b0;
      for (int i = 0; i < NCOEF; i++) begin
        shadow[i] <= COEF_W'(identity_coef(i % NUM_TAPS, COEF_FRAC));
        active[i] <= COEF_W'(identity_coef(i % NUM_TAPS, COEF_FRAC));
      end
      for (int c = 0; c < NUM_CH; c++) begin
        for (int s = 0; s < NUM_STAGES; s++) begin
          hx1[c][s] <= '0;
          hx2[c][s] <= '0;
          hy1[c][s] <= '0;
          hy2[c][s] <= '0;
        end
      end
    end else begin
      if (coef_we && (32'(coef_addr) < 32'(NCOEF))) shadow[coef_addr] <= coef_data;
      out_valid   <= 1'b0;
      commit_pend <= (commit_pend | coef_commit) & (state != IDLE);
      clear_pend  <= (clear_pend | clear_state) & (state != IDLE);
      case (state)
        IDLE: begin
          if (commit_pend || coef_commit) begin
            for (int i = 0; i < NCOEF; i++) active[i] <= shadow[i];
          end
          if (clear_pend || clear_state) begin
            for (int c = 0; c < NUM_CH; c++) begin
              for (int s = 0; s < NUM_STAGES; s++) begin
                hx1[c][s] <= '0;
                hx2[c][s] <= '0;
                hy1[c][s] <= '0;
                hy2[c][s] <= '0;
              end
            end
          end
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            state    <= MAC;
            tap      <= TAP_B0;
            stage    <= '0;
            ch       <= in_channel;
            byp      <= in_bypass;
            cur_x    <= in_data;
            sat_acc  <= 1'b0;
            in_ready <= 1'b0;
          end
        end
        MAC: begin
          if (tap == TAP_A2) state <= NORM;
          else               tap   <= tap + 3'd1;
        end
        NORM: begin
          if (!byp) begin
            cur_x            <= y_new;
            sat_acc          <= sat_acc | norm.sat;
            hx2[ch][stage]   <= hx1[ch][stage];
            hx1[ch][stage]   <= cur_x;
            hy2[ch][stage]   <= hy1[ch][stage];
            hy1[ch][stage]   <= y_new;
          end
          if (stage == ST_W'(NUM_STAGES - 1)) begin
            state <= DONE;
          end else begin
            stage <= stage + ST_W'(1);
            tap   <= TAP_B0;
            state <= MAC;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid   <= 1'b1;
          out_data    <= cur_x;
          out_channel <= ch;
          out_sat     <= sat_acc;
          in_ready    <= !(commit_pend || coef_commit || clear_pend || clear_state);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// tb/tb_iir_biquad_cascade.sv - directed self-checking bench for iir_biquad_cascade
module tb_iir_biquad_cascade;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] in_data = '0;
  logic [0:0]         in_channel = '0;
  logic               in_bypass = 1'b0;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic [0:0]         out_channel;
  logic               out_sat;
  logic               coef_we = 1'b0;
  logic [3:0]         coef_addr = '0;
  logic signed [15:0] coef_data = '0;
  logic               coef_commit = 1'b0;
  logic               clear_state = 1'b0;
  logic               busy;

  int total = 0;
  int bad = 0;

  iir_biquad_cascade dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_channel(in_channel), .in_bypass(in_bypass), .out_valid(out_valid), .out_data(out_data),
    .out_channel(out_channel), .out_sat(out_sat), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .coef_commit(coef_commit), .clear_state(clear_state), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic send(input int x, input int chn, input logic byp, output int y, output logic s,
                      output int oc, output int lat, output logic rdy);
    int guard;
    y = 0; s = 1'b0; oc = -1; lat = -1; rdy = 1'b0; guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) return;
    in_valid = 1'b1; in_data = 16'(x); in_channel = 1'(chn); in_bypass = byp;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_bypass = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = c; y = int'(out_data); s = out_sat; oc = int'(out_channel); rdy = in_ready;
        break;
      end
    end
  endtask

  task automatic wr_coef(input int addr, input int val);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 4'(addr); coef_data = 16'(val);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic pulse_ctl(input logic cm, input logic cl);
    @(negedge clk);
    coef_commit = cm; clear_state = cl;
    @(negedge clk);
    coef_commit = 1'b0; clear_state = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, out_sat, busy} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=1000", {in_ready, out_valid, out_sat, busy});
    end
    total++;
    if (out_data !== 16'sd0 || out_channel !== 1'b0) begin
      bad++;
      $display("FAIL reset_data got=%0d/%0d want=0/0", out_data, out_channel);
    end
  endtask

  task automatic test_identity;
    int y, oc, lat;
    logic s, rdy;
    send(12345, 0, 1'b0, y, s, oc, lat, rdy);
    total++;
    if (lat !== 13) begin bad++; $display("FAIL identity_latency got=%0d want=13", lat); end
    total++;
    if (y !== 12345) begin bad++; $display("FAIL identity_data got=%0d want=12345", y); end
    total++;
    if (s !== 1'b0 || oc !== 0 || rdy !== 1'b1) begin
      bad++;
      $display("FAIL identity_flags got sat=%b ch=%0d rdy=%b want 0/0/1", s, oc, rdy);
    end
  endtask

  task automatic test_fir;
    int xs[4] = '{16384, 7, 0, 0};
    logic bp[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int ex[4] = '{8192, 7, 4096, 0};
    int y, oc, lat;
    logic s, rdy;
    wr_coef(0, 8192);
    wr_coef(1, 4096);
    pulse_ctl(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      send(xs[k], 0, bp[k], y, s, oc, lat, rdy);
      total++;
      if (y !== ex[k] || s !== 1'b0 || lat !== 13) begin
        bad++;
        $display("FAIL fir_%0d got=%0d sat=%b lat=%0d want=%0d sat=0 lat=13", k, y, s, lat, ex[k]);
      end
    end
  endtask

  task automatic test_channels;
    int y, oc, lat;
    logic s, rdy;
    wr_coef(0, 16384);
    wr_coef(1, 0);
    wr_coef(3, -8192);
    pulse_ctl(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      send((k == 0) ? 16384 : 0, 0, 1'b0, y, s, oc, lat, rdy);
      total++;
      if (y !== (16384 >> k) || oc !== 0) begin
        bad++;
        $display("FAIL chan0_%0d got=%0d ch=%0d want=%0d ch=0", k, y, oc, 16384 >> k);
      end
      send(0, 1, 1'b0, y, s, oc, lat, rdy);
      total++;
      if (y !== 0 || oc !== 1) begin
        bad++;
        $display("FAIL chan1_%0d got=%0d ch=%0d want=0 ch=1", k, y, oc);
      end
    end
    pulse_ctl(1'b0, 1'b1);
    send(0, 0, 1'b0, y, s, oc, lat, rdy);
    total++;
    if (y !== 0) begin bad++; $display("FAIL clear_state got=%0d want=0", y); end
  endtask

  task automatic test_saturation;
    int xs[3] = '{32767, -32768, 100};
    int ex[3] = '{32767, -32768, 200};
    logic es[3] = '{1'b1, 1'b1, 1'b0};
    int y, oc, lat;
    logic s, rdy;
    wr_coef(0, 32767);
    wr_coef(3, 0);
    pulse_ctl(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      send(xs[k], 0, 1'b0, y, s, oc, lat, rdy);
      total++;
      if (y !== ex[k] || s !== es[k]) begin
        bad++;
        $display("FAIL sat_%0d got=%0d sat=%b want=%0d sat=%b", k, y, s, ex[k], es[k]);
      end
    end
  endtask

  task automatic test_commit_busy;
    int y, oc, lat, guard;
    logic s, rdy;
    time t0;
    wr_coef(0, 16384);
    pulse_ctl(1'b1, 1'b1);
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    in_valid = 1'b1; in_data = 16'sd12345; in_channel = 1'b1;
    @(posedge clk);
    #1;
    t0 = $time;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 16'sd8192;
    @(negedge clk);
    coef_we = 1'b0; coef_commit = 1'b1;
    @(negedge clk);
    coef_commit = 1'b0;
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL commit_pending got busy=%b rdy=%b want 1/0", busy, in_ready);
    end
    lat = -1; y = 0; rdy = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin lat = int'(($time - t0) / 10); y = int'(out_data); rdy = in_ready; break; end
    end
    total++;
    if (y !== 12345 || lat !== 13 || rdy !== 1'b0) begin
      bad++;
      $display("FAIL commit_old got=%0d lat=%0d rdy=%b want=12345 lat=13 rdy=0", y, lat, rdy);
    end
    send(12344, 1, 1'b0, y, s, oc, lat, rdy);
    total++;
    if (y !== 6172 || oc !== 1) begin
      bad++;
      $display("FAIL commit_new got=%0d ch=%0d want=6172 ch=1", y, oc);
    end
  endtask

  task automatic test_reset_mid;
    int y, oc, lat, guard;
    logic s, rdy, seen;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    in_valid = 1'b1; in_data = 16'sd1000; in_channel = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    total++;
    if ({in_ready, out_valid, out_sat, busy} !== 4'b1000 || out_data !== 16'sd0 || out_channel !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_outputs got=%b data=%0d ch=%0d want=1000 data=0 ch=0",
               {in_ready, out_valid, out_sat, busy}, out_data, out_channel);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL reset_mid_no_output got=%b want=0", seen); end
    send(12345, 0, 1'b0, y, s, oc, lat, rdy);
    total++;
    if (y !== 12345) begin bad++; $display("FAIL reset_bank_identity got=%0d want=12345", y); end
  endtask

  initial begin
    test_reset;
    test_identity;
    test_fir;
    test_channels;
    test_saturation;
    test_commit_busy;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
